mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data wins by default; a grant streak limit and a ready timeout bound every wait.
module mem_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_sel,
    output logic              port_valid,
    output logic              port_we,
    output logic [DATA_W-1:0] port_wdata,
    input  logic              port_ready,
    input  logic [DATA_W-1:0] port_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err_timeout,
    output logic [1:0]        o_dbg_state
);
    // Handshake: a requester raises x_req and holds addr/data stable until the
    // one-cycle x_ack pulse; the memory ends an access by asserting port_ready
    // while port_valid is high, with port_rdata valid in that same cycle.

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_if_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_mem_sel;
    logic              r_port_valid;
    logic              r_port_we;
    logic [DATA_W-1:0] r_port_wdata;
    logic              r_err_timeout;
    logic [SW-1:0]     r_streak;
    logic [TW-1:0]     r_tcnt;

    logic w_i_elig;
    logic w_d_elig;
    logic w_grant_d;
    logic w_grant_i;
    logic w_unused;

    // The address mux lives outside this block; addresses only pass through it.
    assign w_unused = ^{if_addr, d_addr};

    // A requester whose ack is high this cycle is finishing, not asking again.
    always_comb begin
        w_i_elig  = if_req & ~r_if_ack;
        w_d_elig  = d_req & ~r_d_ack;
        w_grant_d = (r_state == ST_IDLE) & w_d_elig & (~w_i_elig | (r_streak != STREAK_MAX));
        w_grant_i = (r_state == ST_IDLE) & w_i_elig & ~w_grant_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_mem_sel     <= 1'b0;
            r_port_valid  <= 1'b0;
            r_port_we     <= 1'b0;
            r_port_wdata  <= '0;
            r_err_timeout <= 1'b0;
            r_streak      <= '0;
            r_tcnt        <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state      <= ST_BUSY_D;
                        r_mem_sel    <= 1'b1;
                        r_port_we    <= d_we;
                        r_port_wdata <= d_wdata;
                        r_port_valid <= 1'b1;
                        r_tcnt       <= '0;
                        if (!if_req) begin
                            r_streak <= '0;
                        end else if (r_streak != STREAK_MAX) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_state      <= ST_BUSY_I;
                        r_mem_sel    <= 1'b0;
                        r_port_we    <= 1'b0;
                        r_port_wdata <= '0;
                        r_port_valid <= 1'b1;
                        r_tcnt       <= '0;
                        r_streak     <= '0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (port_ready || (r_tcnt == TCNT_LAST)) begin
                        r_state      <= ST_IDLE;
                        r_port_valid <= 1'b0;
                        if (!port_ready) begin
                            r_err_timeout <= 1'b1;
                        end
                        // An aborted access returns zero rather than bus garbage.
                        if (r_state == ST_BUSY_I) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= port_ready ? port_rdata : '0;
                        end else begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= port_ready ? port_rdata : '0;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_port_valid <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack      = r_if_ack;
    assign d_ack       = r_d_ack;
    assign if_rdata    = r_if_rdata;
    assign d_rdata     = r_d_rdata;
    assign mem_sel     = r_mem_sel;
    assign port_valid  = r_port_valid;
    assign port_we     = r_port_we;
    assign port_wdata  = r_port_wdata;
    assign err_timeout = r_err_timeout;
    assign o_dbg_state = r_state;

    assign stall_if  = if_req & ~r_if_ack & ~((r_state == ST_BUSY_I) & port_ready);
    assign stall_mem = d_req & ~r_d_ack & ~((r_state == ST_BUSY_D) & port_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level
// reference of the fetch/data memory port arbiter.
module tb_mem_port_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int MAX_D = 4;
    localparam int TOUT  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_sel;
    logic          port_valid;
    logic          port_we;
    logic [DW-1:0] port_wdata;
    logic          port_ready;
    logic [DW-1:0] port_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          err_timeout;
    logic [1:0]    o_dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .MAX_D_STREAK(MAX_D), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_sel(mem_sel), .port_valid(port_valid), .port_we(port_we),
        .port_wdata(port_wdata), .port_ready(port_ready), .port_rdata(port_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .err_timeout(err_timeout),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; port_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; port_rdata = '0;
        tick(); tick();
        n_checks++; if ({if_ack, d_ack, port_valid, mem_sel, port_we, err_timeout, stall_if, stall_mem} !== 8'h00)
            $display("FAIL reset_flags: got %b want 00000000", {if_ack, d_ack, port_valid, mem_sel, port_we, err_timeout, stall_if, stall_mem}); else n_pass++;
        n_checks++; if ({if_rdata, d_rdata, port_wdata} !== '0)
            $display("FAIL reset_data: got %h %h %h want all zero", if_rdata, d_rdata, port_wdata); else n_pass++;
        n_checks++; if (o_dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", o_dbg_state); else n_pass++;
        // Start a data access, then reset while it is in flight.
        reset_n = 1'b1; d_req = 1'b1;
        tick();
        n_checks++; if (port_valid !== 1'b1) $display("FAIL reset_pre_busy: port_valid %b want 1", port_valid); else n_pass++;
        reset_n = 1'b0;
        tick();
        n_checks++; if ({port_valid, d_ack, mem_sel} !== 3'b000)
            $display("FAIL reset_mid_busy: valid/ack/sel %b want 000", {port_valid, d_ack, mem_sel}); else n_pass++;
        d_req = 1'b0; reset_n = 1'b1;
        tick();
        n_checks++; if (d_ack !== 1'b0) $display("FAIL reset_no_ack: d_ack %b want 0", d_ack); else n_pass++;
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        n_checks++; if (stall_if !== 1'b1) $display("FAIL fetch_stall_idle: %b want 1", stall_if); else n_pass++;
        tick();
        n_checks++; if ({port_valid, mem_sel, port_we} !== 3'b100)
            $display("FAIL fetch_grant: valid/sel/we %b want 100", {port_valid, mem_sel, port_we}); else n_pass++;
        tick();
        port_ready = 1'b1; port_rdata = 32'h8C010004;
        #1;
        n_checks++; if (stall_if !== 1'b0) $display("FAIL fetch_stall_ready: %b want 0", stall_if); else n_pass++;
        tick();
        n_checks++; if ({if_ack, port_valid} !== 2'b10) $display("FAIL fetch_ack: ack/valid %b want 10", {if_ack, port_valid}); else n_pass++;
        n_checks++; if (if_rdata !== 32'h8C010004) $display("FAIL fetch_rdata: got %h want 8c010004", if_rdata); else n_pass++;
        if_req = 1'b0; port_ready = 1'b0; port_rdata = 32'h0;
        tick();
        n_checks++; if ({if_ack, if_rdata} !== {1'b0, 32'h8C010004})
            $display("FAIL fetch_hold: ack %b rdata %h want 0 8c010004", if_ack, if_rdata); else n_pass++;
    endtask

    task automatic test_both();
        if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick();
        port_ready = 1'b1; port_rdata = 32'h11112222;
        #1;
        n_checks++; if ({port_valid, mem_sel, stall_if, stall_mem} !== 4'b1110)
            $display("FAIL both_d_first: valid/sel/stall_if/stall_mem %b want 1110", {port_valid, mem_sel, stall_if, stall_mem}); else n_pass++;
        tick();
        n_checks++; if ({d_ack, d_rdata, stall_if} !== {1'b1, 32'h11112222, 1'b1})
            $display("FAIL both_d_ack: ack %b rdata %h stall_if %b want 1 11112222 1", d_ack, d_rdata, stall_if); else n_pass++;
        d_req = 1'b0; port_rdata = 32'h33334444;
        tick();
        n_checks++; if ({port_valid, mem_sel, stall_if} !== 3'b100)
            $display("FAIL both_i_second: valid/sel/stall_if %b want 100", {port_valid, mem_sel, stall_if}); else n_pass++;
        tick();
        n_checks++; if ({if_ack, if_rdata} !== {1'b1, 32'h33334444})
            $display("FAIL both_i_ack: ack %b rdata %h want 1 33334444", if_ack, if_rdata); else n_pass++;
        if_req = 1'b0; port_ready = 1'b0;
        tick();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        tick();
        n_checks++; if ({port_valid, port_we, mem_sel, port_wdata} !== {3'b111, 32'hDEADBEEF})
            $display("FAIL store_grant: v/we/sel %b wdata %h want 111 deadbeef", {port_valid, port_we, mem_sel}, port_wdata); else n_pass++;
        tick();
        n_checks++; if ({port_valid, port_we, port_wdata} !== {2'b11, 32'hDEADBEEF})
            $display("FAIL store_hold: v/we %b wdata %h want 11 deadbeef", {port_valid, port_we}, port_wdata); else n_pass++;
        port_ready = 1'b1;
        tick();
        n_checks++; if ({d_ack, port_valid} !== 2'b10) $display("FAIL store_ack: ack/valid %b want 10", {d_ack, port_valid}); else n_pass++;
        d_req = 1'b0; d_we = 1'b0; port_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n_busy;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; port_ready = 1'b0; port_rdata = 32'hA5A5A5A5;
        tick();
        n_busy = 0;
        for (int k = 0; k < 40 && port_valid; k++) begin
            n_busy++;
            tick();
        end
        n_checks++; if (n_busy != TOUT) $display("FAIL timeout_len: busy cycles %0d want %0d", n_busy, TOUT); else n_pass++;
        n_checks++; if ({d_ack, d_rdata, err_timeout} !== {1'b1, 32'h0, 1'b1})
            $display("FAIL timeout_ack: ack %b rdata %h err %b want 1 0 1", d_ack, d_rdata, err_timeout); else n_pass++;
        d_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h80; port_ready = 1'b1; port_rdata = 32'h0BADF00D;
        tick(); tick();
        n_checks++; if ({if_ack, if_rdata, err_timeout} !== {1'b1, 32'h0BADF00D, 1'b1})
            $display("FAIL timeout_recover: ack %b rdata %h err %b want 1 0badf00d 1", if_ack, if_rdata, err_timeout); else n_pass++;
        if_req = 1'b0; port_ready = 1'b0;
        tick();
    endtask

    // Fetch withdraws during data accesses and re-asks only in quiet IDLE
    // cycles, so it can only win through the streak limit.
    task automatic test_streak();
        int  grants[$];
        int  exp_g[$];
        bit  hold;
        bit  i_done;
        bit  ok;
        exp_g = '{1, 1, 1, 1, 0, 1};
        hold = 0; i_done = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; port_ready = 1'b1;
        for (int c = 0; c < 80 && grants.size() < 6; c++) begin
            if (i_done) if_req = 1'b0;
            else if (hold) begin
                if (if_ack) begin if_req = 1'b0; i_done = 1; hold = 0; end
            end else if_req = !(port_valid || d_ack);
            port_rdata = $urandom;
            tick();
            if (port_valid) begin
                grants.push_back(int'(mem_sel));
                if (!mem_sel) hold = 1;
            end
        end
        ok = (grants.size() == 6);
        for (int k = 0; k < grants.size() && k < 6; k++) if (grants[k] != exp_g[k]) ok = 0;
        n_checks++; if (!ok) $display("FAIL streak_order: grants %p want %p (1=data)", grants, exp_g); else n_pass++;
        d_req = 1'b0; if_req = 1'b0; port_ready = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_random();
        int          m_owner;   // 0 idle, 1 fetch access, 2 data access
        int          m_wait;
        int          m_streak;
        bit          m_if_ack, m_d_ack, m_pv, m_sel, m_we, m_err;
        bit          ie, de, hang, i_act, d_act;
        logic [DW-1:0] m_if_rdata, m_d_rdata, m_wdata;
        reset_n = 1'b0; if_req = 0; d_req = 0; port_ready = 0;
        tick();
        reset_n = 1'b1;
        m_owner = 0; m_wait = 0; m_streak = 0; m_if_ack = 0; m_d_ack = 0; m_pv = 0;
        m_sel = 0; m_we = 0; m_err = 0; m_if_rdata = '0; m_d_rdata = '0; m_wdata = '0;
        i_act = 0; d_act = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (m_if_ack) i_act = 0;
            if (m_d_ack) d_act = 0;
            if (!i_act && $urandom_range(0, 2) == 0) begin i_act = 1; if_addr = $urandom; end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; d_addr = $urandom; d_we = $urandom_range(0, 1) == 1; d_wdata = $urandom;
            end
            if_req = i_act; d_req = d_act;
            hang = (cyc % 300) >= 240;
            port_ready = hang ? 1'b0 : ($urandom_range(0, 2) == 0);
            port_rdata = $urandom;
            #1;
            n_checks++; if (stall_if !== (if_req && !m_if_ack && !(m_owner == 1 && port_ready)))
                $display("FAIL rnd_stall_if cyc %0d: got %b", cyc, stall_if); else n_pass++;
            n_checks++; if (stall_mem !== (d_req && !m_d_ack && !(m_owner == 2 && port_ready)))
                $display("FAIL rnd_stall_mem cyc %0d: got %b", cyc, stall_mem); else n_pass++;
            ie = if_req && !m_if_ack;
            de = d_req && !m_d_ack;
            m_if_ack = 0; m_d_ack = 0;
            if (m_owner == 0) begin
                if (de && (!ie || m_streak < MAX_D)) begin
                    m_owner = 2; m_sel = 1; m_we = d_we; m_wdata = d_wdata; m_pv = 1; m_wait = 0;
                    m_streak = if_req ? ((m_streak < MAX_D) ? m_streak + 1 : MAX_D) : 0;
                end else if (ie) begin
                    m_owner = 1; m_sel = 0; m_we = 0; m_pv = 1; m_wait = 0; m_streak = 0;
                end
            end else if (port_ready || m_wait == TOUT - 1) begin
                if (m_owner == 1) begin m_if_ack = 1; m_if_rdata = port_ready ? port_rdata : '0; end
                else begin m_d_ack = 1; m_d_rdata = port_ready ? port_rdata : '0; end
                if (!port_ready) m_err = 1;
                m_owner = 0; m_pv = 0;
            end else m_wait++;
            tick();
            n_checks++; if ({if_ack, d_ack, port_valid, mem_sel, err_timeout} !== {m_if_ack, m_d_ack, m_pv, m_sel, m_err})
                $display("FAIL rnd_ctrl cyc %0d: ack_i/ack_d/valid/sel/err got %b want %b", cyc,
                         {if_ack, d_ack, port_valid, mem_sel, err_timeout}, {m_if_ack, m_d_ack, m_pv, m_sel, m_err}); else n_pass++;
            n_checks++; if ({if_rdata, d_rdata} !== {m_if_rdata, m_d_rdata})
                $display("FAIL rnd_rdata cyc %0d: got %h %h want %h %h", cyc, if_rdata, d_rdata, m_if_rdata, m_d_rdata); else n_pass++;
            if (m_pv) begin
                n_checks++; if (port_we !== m_we) $display("FAIL rnd_we cyc %0d: got %b want %b", cyc, port_we, m_we); else n_pass++;
                if (m_we) begin
                    n_checks++; if (port_wdata !== m_wdata)
                        $display("FAIL rnd_wdata cyc %0d: got %h want %h", cyc, port_wdata, m_wdata); else n_pass++;
                end
            end
        end
        if_req = 0; d_req = 0; port_ready = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_store();
        test_timeout();
        test_streak();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
